// File: rtl/onebit_comparator_checker.sv
// onebit_comparator_checker
//   Drives the four x/y input combinations into a one-bit comparator, holds
//   each one for HOLD_CYCLES cycles, and samples g/l/e on the last cycle of
//   each hold window. Mismatches are counted (saturating) and recorded per
//   vector. At the end of a run it emits a one-cycle done pulse and a pass
//   verdict.
//   Optional feature macro: CMP_CHECKER_STOP_ON_ERR_EN
//     When defined, the first mismatch ends the run immediately.
module onebit_comparator_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int LOOPS       = 1,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x,
  output logic             y,
  input  logic             g,
  input  logic             l,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       err_vec
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Comparator response bundle, ordered {g,l,e}
  typedef struct packed {
    logic g;
    logic l;
    logic e;
  } resp_t;

  // Expected one-hot response for vector v = {x,y}
  function automatic resp_t exp_resp(input logic [1:0] v);
    resp_t r;
    r = '0;
    case (v)
      2'd1:    r.l = 1'b1;  // x=0, y=1 -> x<y
      2'd2:    r.g = 1'b1;  // x=1, y=0 -> x>y
      default: r.e = 1'b1;  // 00 and 11 -> equal
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [3:0]         err_vec_q, err_vec_d;

  resp_t resp_obs;
  logic  sample;
  logic  mismatch;
  logic  last_vec;
  logic  end_run;

  assign resp_obs = '{g: g, l: l, e: e};

  // Last cycle of a hold window: the comparator has had the full window to settle
  assign sample   = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
  // Any deviation from the one-hot pattern (including 000 or multi-hot) counts
  assign mismatch = sample && (resp_obs != exp_resp(vec_q));
  assign last_vec = (vec_q == 2'd3) && (loop_q == LOOP_LAST);

`ifdef CMP_CHECKER_STOP_ON_ERR_EN
  assign end_run = sample && (last_vec || mismatch);
`else
  assign end_run = sample && last_vec;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      hold_q      <= '0;
      loop_q      <= '0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hold_q      <= hold_d;
      loop_q      <= loop_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_vec_q   <= err_vec_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    hold_d      = hold_q;
    loop_d      = loop_q;
    x_d         = x_q;
    y_d         = y_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_vec_d   = err_vec_q;

    case (state_q)
      S_IDLE: begin
        x_d = 1'b0;
        y_d = 1'b0;
        if (start) begin
          state_d     = S_DRIVE;
          vec_d       = '0;
          hold_d      = '0;
          loop_d      = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_vec_d   = '0;
          // Vector 0 is 00, so x/y already present it from the first DRIVE cycle
        end
      end

      S_DRIVE: begin
        hold_d = hold_q + 1'b1;
        if (mismatch) begin
          if (err_count_q != {ERR_W{1'b1}})
            err_count_d = err_count_q + 1'b1;
          err_vec_d[vec_q] = 1'b1;
        end
        if (sample) begin
          hold_d = '0;
          vec_d  = vec_q + 1'b1;
          if (vec_q == 2'd3)
            loop_d = loop_q + 1'b1;
        end
        if (end_run) begin
          // Verdict includes a mismatch caught in this very sample cycle
          state_d = S_FINISH;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
          vec_d   = '0;
          loop_d  = '0;
          x_d     = 1'b0;
          y_d     = 1'b0;
        end else begin
          x_d = vec_d[1];
          y_d = vec_d[0];
        end
      end

      S_FINISH: begin
        // start is not looked at here; only IDLE accepts a run
        state_d = S_IDLE;
        busy_d  = 1'b0;
        x_d     = 1'b0;
        y_d     = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        x_d     = 1'b0;
        y_d     = 1'b0;
      end
    endcase
  end

  assign x         = x_q;
  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_vec   = err_vec_q;

endmodule
